// File: rtl/coin_pkg.sv
// Shared types and constants for the coin dispenser: FSM state, amount width, coin values.
// Latency: none (types and constants only).
// Backpressure: none; the dispenser is paced by coin_ack from the mechanism.
package coin_pkg;

    localparam int AMT_W = 5;

    localparam logic [AMT_W-1:0] VAL_NKL  = 5'd1;
    localparam logic [AMT_W-1:0] VAL_DIME = 5'd2;
    localparam logic [AMT_W-1:0] VAL_QTR  = 5'd5;
    localparam logic [AMT_W-1:0] VAL_DLR  = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // One request line per denomination; at most one bit set.
    typedef struct packed {
        logic dollar;
        logic quarter;
        logic dime;
        logic nickel;
    } coin_sel_t;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination not exceeding the remaining amount (COIN_DISPENSE_DOLLAR_EN adds dollar).
// Latency: purely combinational.
// Backpressure: none; output simply follows the remaining-amount input.
module coin_select
    import coin_pkg::*;
(
    input  logic [AMT_W-1:0] rem_i,
    output coin_sel_t        sel_o,
    output logic [AMT_W-1:0] val_o
);

    // Pick one coin; zero remaining selects nothing so the subtracted value is never larger than R.
    always_comb begin
        sel_o = '0;
        val_o = '0;
`ifdef COIN_DISPENSE_DOLLAR_EN
        if (rem_i >= VAL_DLR) begin
            sel_o.dollar = 1'b1;
            val_o        = VAL_DLR;
        end else
`endif
        if (rem_i >= VAL_QTR) begin
            sel_o.quarter = 1'b1;
            val_o         = VAL_QTR;
        end else if (rem_i >= VAL_DIME) begin
            sel_o.dime = 1'b1;
            val_o      = VAL_DIME;
        end else if (rem_i != '0) begin
            sel_o.nickel = 1'b1;
            val_o        = VAL_NKL;
        end
    end

endmodule

// File: rtl/coin_dispense.sv
// Coin payout sequencer: loads an amount, requests coins one at a time, pulses done at completion.
// Latency: first coin line high right after the load edge; done high right after the last ack edge.
// Backpressure: each coin line held until coin_ack; enable=0 freezes everything (COIN_DISPENSE_DOLLAR_EN optional).
module coin_dispense
    import coin_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [AMT_W-1:0] amount,
    input  logic             coin_ack,
    output logic             dollar,
    output logic             quarter,
    output logic             dime,
    output logic             nickel,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining
);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;

    coin_sel_t        sel;
    logic [AMT_W-1:0] sel_val;
    logic [AMT_W-1:0] rem_after;

    // The coin on offer is always derived from the registered remaining amount.
    coin_select u_sel (
        .rem_i (rem_q),
        .sel_o (sel),
        .val_o (sel_val)
    );

    // sel_val <= rem_q by construction, so this never wraps.
    assign rem_after = rem_q - sel_val;

    // State and remaining-amount registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic; nothing advances unless enable is high.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        rem_d   = amount;
                        state_d = (amount != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (coin_ack) begin
                        rem_d = rem_after;
                        if (rem_after == '0) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode straight from registers, so they change only at clock edges or reset.
    always_comb begin
        dollar    = 1'b0;
        quarter   = 1'b0;
        dime      = 1'b0;
        nickel    = 1'b0;
        busy      = (state_q == ST_ISSUE);
        done      = (state_q == ST_DONE);
        remaining = rem_q;
        if (state_q == ST_ISSUE) begin
            dollar  = sel.dollar;
            quarter = sel.quarter;
            dime    = sel.dime;
            nickel  = sel.nickel;
        end
    end

endmodule

// File: tb/tb_coin_dispense.sv
// Directed bench for coin_dispense: hand-computed coin sequences, enable freeze, reset abort, load ignore.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: coin_ack driven directly by the stimulus sequence.
module tb_coin_dispense;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [4:0] amount;
    logic       coin_ack;
    logic       dollar, quarter, dime, nickel, busy, done;
    logic [4:0] remaining;

    int checks;
    int errors;

    // {dollar, quarter, dime, nickel}
    localparam logic [3:0] C_0 = 4'b0000;
    localparam logic [3:0] C_L = 4'b1000;
    localparam logic [3:0] C_Q = 4'b0100;
    localparam logic [3:0] C_D = 4'b0010;
    localparam logic [3:0] C_N = 4'b0001;

    coin_dispense dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .amount    (amount),
        .coin_ack  (coin_ack),
        .dollar    (dollar),
        .quarter   (quarter),
        .dime      (dime),
        .nickel    (nickel),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] coin, input logic b,
                         input logic d, input logic [4:0] r);
        logic [10:0] obs;
        logic [10:0] expv;
        obs  = {dollar, quarter, dime, nickel, busy, done, remaining};
        expv = {coin, b, d, r};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed coins/busy/done/rem=%b required=%b", tag, obs, expv);
        end
    endtask

    logic [3:0] seq_c[6];
    logic [4:0] seq_r[6];
    int         seq_n;
    logic [4:0] rem31_after2;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        load     = 1'b0;
        amount   = '0;
        coin_ack = 1'b0;

`ifdef COIN_DISPENSE_DOLLAR_EN
        seq_n = 3;
        seq_c[0] = C_L; seq_r[0] = 5'd23;
        seq_c[1] = C_D; seq_r[1] = 5'd3;
        seq_c[2] = C_N; seq_r[2] = 5'd1;
        seq_c[3] = C_0; seq_r[3] = 5'd0;
        seq_c[4] = C_0; seq_r[4] = 5'd0;
        seq_c[5] = C_0; seq_r[5] = 5'd0;
        rem31_after2 = 5'd6;
`else
        seq_n = 6;
        seq_c[0] = C_Q; seq_r[0] = 5'd23;
        seq_c[1] = C_Q; seq_r[1] = 5'd18;
        seq_c[2] = C_Q; seq_r[2] = 5'd13;
        seq_c[3] = C_Q; seq_r[3] = 5'd8;
        seq_c[4] = C_D; seq_r[4] = 5'd3;
        seq_c[5] = C_N; seq_r[5] = 5'd1;
        rem31_after2 = 5'd21;
`endif

        // Reset state
        #3;
        check("reset_state", C_0, 1'b0, 1'b0, 5'd0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_release", C_0, 1'b0, 1'b0, 5'd0);

        // amount=13, ack every cycle: Q, Q, D, N
        load = 1'b1; amount = 5'd13;
        tick();
        load = 1'b0; amount = 5'd0; coin_ack = 1'b1;
        check("a13_c1", C_Q, 1'b1, 1'b0, 5'd13);
        tick();
        check("a13_c2", C_Q, 1'b1, 1'b0, 5'd8);
        tick();
        check("a13_c3", C_D, 1'b1, 1'b0, 5'd3);
        tick();
        check("a13_c4", C_N, 1'b1, 1'b0, 5'd1);
        tick();
        coin_ack = 1'b0;
        check("a13_done", C_0, 1'b0, 1'b1, 5'd0);
        tick();
        check("a13_idle", C_0, 1'b0, 1'b0, 5'd0);

        // amount=0: straight to done, never busy
        load = 1'b1; amount = 5'd0;
        tick();
        load = 1'b0;
        check("a0_done", C_0, 1'b0, 1'b1, 5'd0);
        tick();
        check("a0_idle", C_0, 1'b0, 1'b0, 5'd0);

        // amount=4, slow acks, enable low mid-payout with an ack that must be ignored
        load = 1'b1; amount = 5'd4;
        tick();
        load = 1'b0;
        check("a4_d1_first", C_D, 1'b1, 1'b0, 5'd4);
        tick();
        tick();
        check("a4_d1_wait", C_D, 1'b1, 1'b0, 5'd4);
        enable = 1'b0; coin_ack = 1'b1;
        tick();
        check("a4_frozen1", C_D, 1'b1, 1'b0, 5'd4);
        tick();
        check("a4_frozen2", C_D, 1'b1, 1'b0, 5'd4);
        enable = 1'b1; coin_ack = 1'b0;
        tick();
        check("a4_d1_hold", C_D, 1'b1, 1'b0, 5'd4);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("a4_d2_first", C_D, 1'b1, 1'b0, 5'd2);
        tick();
        tick();
        check("a4_d2_wait", C_D, 1'b1, 1'b0, 5'd2);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("a4_done", C_0, 1'b0, 1'b1, 5'd0);
        enable = 1'b0;
        tick();
        check("a4_done_held", C_0, 1'b0, 1'b1, 5'd0);
        enable = 1'b1;
        tick();
        check("a4_idle", C_0, 1'b0, 1'b0, 5'd0);

        // amount=23: dollar path depends on build option
        load = 1'b1; amount = 5'd23;
        tick();
        load = 1'b0; coin_ack = 1'b1;
        for (int i = 0; i < seq_n; i++) begin
            check($sformatf("a23_c%0d", i), seq_c[i], 1'b1, 1'b0, seq_r[i]);
            tick();
        end
        coin_ack = 1'b0;
        check("a23_done", C_0, 1'b0, 1'b1, 5'd0);
        tick();

        // amount=31, reset after the 2nd ack abandons payout
        load = 1'b1; amount = 5'd31;
        tick();
        load = 1'b0; coin_ack = 1'b1;
        tick();
        tick();
        check("a31_after2", C_Q, 1'b1, 1'b0, rem31_after2);
        reset = 1'b1;
        #1;
        check("a31_reset_async", C_0, 1'b0, 1'b0, 5'd0);
        tick();
        reset = 1'b0;
        tick();
        check("a31_ack_ignored", C_0, 1'b0, 1'b0, 5'd0);
        tick();
        check("a31_no_done", C_0, 1'b0, 1'b0, 5'd0);
        coin_ack = 1'b0;
        load = 1'b1; amount = 5'd1;
        tick();
        load = 1'b0; coin_ack = 1'b1;
        check("a1_nickel", C_N, 1'b1, 1'b0, 5'd1);
        tick();
        coin_ack = 1'b0;
        check("a1_done", C_0, 1'b0, 1'b1, 5'd0);
        tick();

        // amount=2 with a competing load of 7 that must be ignored
        load = 1'b1; amount = 5'd2;
        tick();
        amount = 5'd7;
        check("a2_dime", C_D, 1'b1, 1'b0, 5'd2);
        tick();
        check("a2_reload_ignored", C_D, 1'b1, 1'b0, 5'd2);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0; load = 1'b0;
        check("a2_done", C_0, 1'b0, 1'b1, 5'd0);
        tick();
        check("a2_idle", C_0, 1'b0, 1'b0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
